// File: rtl/operand_stack_if.sv
// Operand stack command/status bundle: the controller drives op/din/clr_err, the stack
// returns its top two entries and occupancy/error status.
interface operand_stack_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 4
) ();
   logic [2:0]       op;
   logic [WIDTH-1:0] din;
   logic             clr_err;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [AW-1:0]    index;
   logic [AW:0]      count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   modport master (
      output op, din, clr_err,
      input  tos, nos, index, count, empty, full, overflow, underflow
   );

   modport slave (
      input  op, din, clr_err,
      output tos, nos, index, count, empty, full, overflow, underflow
   );
endinterface

// File: rtl/operand_stack.sv
// LIFO operand stack feeding the ALU (tos/nos) with single-cycle pop-two/push-one writeback.
// Define OPERAND_STACK_DUP_SWAP_EN to enable DUP (100) and SWAP (101); otherwise they are NOPs.
module operand_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input logic            clk,
   input logic            reset,
   operand_stack_if.slave stk
);

   localparam logic [2:0] OpPush  = 3'b001;
   localparam logic [2:0] OpPop   = 3'b010;
   localparam logic [2:0] OpBinop = 3'b011;
`ifdef OPERAND_STACK_DUP_SWAP_EN
   localparam logic [2:0] OpDup   = 3'b100;
   localparam logic [2:0] OpSwap  = 3'b101;
`endif

   localparam logic [AW:0] CntOne  = (AW+1)'(1);
   localparam logic [AW:0] CntTwo  = (AW+1)'(2);
   localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic             is_empty, is_full, has_two;
   logic [AW-1:0]    free_idx, top_idx, nos_idx;

   logic             wr_a_en;
   logic [AW-1:0]    wr_a_addr;
   logic [WIDTH-1:0] wr_a_data;
`ifdef OPERAND_STACK_DUP_SWAP_EN
   logic             wr_b_en;
   logic [AW-1:0]    wr_b_addr;
   logic [WIDTH-1:0] wr_b_data;
`endif

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CntFull);
   assign has_two  = (count_q >= CntTwo);

   // At count==DEPTH the low bits wrap to 0, so top_idx correctly lands on DEPTH-1.
   assign free_idx = count_q[AW-1:0];
   assign top_idx  = is_empty ? '0 : (free_idx - AW'(1));
   assign nos_idx  = top_idx - AW'(1);

   always_comb begin
      count_d     = count_q;
      overflow_d  = overflow_q  & ~stk.clr_err;
      underflow_d = underflow_q & ~stk.clr_err;
      wr_a_en     = 1'b0;
      wr_a_addr   = free_idx;
      wr_a_data   = stk.din;
`ifdef OPERAND_STACK_DUP_SWAP_EN
      wr_b_en     = 1'b0;
      wr_b_addr   = nos_idx;
      wr_b_data   = mem_q[top_idx];
`endif

      case (stk.op)
         OpPush: begin
            if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               wr_a_en = 1'b1;
               count_d = count_q + CntOne;
            end
         end
         OpPop: begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else begin
               count_d = count_q - CntOne;
            end
         end
         OpBinop: begin
            // ALU result overwrites nos; the old tos slot simply falls off the top.
            if (!has_two) begin
               underflow_d = 1'b1;
            end else begin
               wr_a_en   = 1'b1;
               wr_a_addr = nos_idx;
               count_d   = count_q - CntOne;
            end
         end
`ifdef OPERAND_STACK_DUP_SWAP_EN
         OpDup: begin
            if (is_empty) begin
               underflow_d = 1'b1;
            end else if (is_full) begin
               overflow_d = 1'b1;
            end else begin
               wr_a_en   = 1'b1;
               wr_a_data = mem_q[top_idx];
               count_d   = count_q + CntOne;
            end
         end
         OpSwap: begin
            if (!has_two) begin
               underflow_d = 1'b1;
            end else begin
               wr_a_en   = 1'b1;
               wr_a_addr = top_idx;
               wr_a_data = mem_q[nos_idx];
               wr_b_en   = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage is not reset: a write landing while reset is held is invisible because
   // count is pinned at 0 and every read is gated by occupancy.
   always_ff @(posedge clk) begin
      if (wr_a_en) begin
         mem_q[wr_a_addr] <= wr_a_data;
      end
`ifdef OPERAND_STACK_DUP_SWAP_EN
      if (wr_b_en) begin
         mem_q[wr_b_addr] <= wr_b_data;
      end
`endif
   end

   assign stk.tos       = is_empty ? '0 : mem_q[top_idx];
   assign stk.nos       = has_two ? mem_q[nos_idx] : '0;
   assign stk.index     = top_idx;
   assign stk.count     = count_q;
   assign stk.empty     = is_empty;
   assign stk.full      = is_full;
   assign stk.overflow  = overflow_q;
   assign stk.underflow = underflow_q;

endmodule

// File: tb/tb_operand_stack.sv
// Self-checking bench for operand_stack: directed scenarios plus random ops against a
// queue-based reference model. Tracks OPERAND_STACK_DUP_SWAP_EN like the design.
module tb_operand_stack;
   localparam int W = 8;
   localparam int D = 16;
   localparam int A = 4;

   localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, BINOP = 3'b011;
   localparam logic [2:0] DUP = 3'b100, SWAP = 3'b101;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   failures = 0;

   operand_stack_if #(.WIDTH(W), .AW(A)) bus ();

   operand_stack #(.WIDTH(W), .DEPTH(D), .AW(A)) dut (
      .clk   (clk),
      .reset (reset),
      .stk   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: top of stack is the back of the queue.
   logic [W-1:0] mq[$];
   logic         m_ovf, m_unf;

   function automatic logic [W-1:0] m_tos();
      return (mq.size() > 0) ? mq[mq.size()-1] : '0;
   endfunction

   function automatic logic [W-1:0] m_nos();
      return (mq.size() > 1) ? mq[mq.size()-2] : '0;
   endfunction

   task automatic model_step(input logic [2:0] op, input logic [W-1:0] din, input logic clr);
      logic [W-1:0] a, b;
      if (clr) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      case (op)
         PUSH:  if (mq.size() == D) m_ovf = 1'b1; else mq.push_back(din);
         POP:   if (mq.size() == 0) m_unf = 1'b1; else void'(mq.pop_back());
         BINOP: begin
            if (mq.size() < 2) m_unf = 1'b1;
            else begin
               void'(mq.pop_back());
               void'(mq.pop_back());
               mq.push_back(din);
            end
         end
`ifdef OPERAND_STACK_DUP_SWAP_EN
         DUP: begin
            if (mq.size() == 0) m_unf = 1'b1;
            else if (mq.size() == D) m_ovf = 1'b1;
            else mq.push_back(mq[mq.size()-1]);
         end
         SWAP: begin
            if (mq.size() < 2) m_unf = 1'b1;
            else begin
               a = mq.pop_back();
               b = mq.pop_back();
               mq.push_back(a);
               mq.push_back(b);
            end
         end
`endif
         default: ;
      endcase
   endtask

   // Apply one op across a rising edge; returns #1 after that edge with inputs idle.
   task automatic do_op(input logic [2:0] op, input logic [W-1:0] din, input logic clr);
      bus.op = op;
      bus.din = din;
      bus.clr_err = clr;
      @(posedge clk);
      model_step(op, din, clr);
      #1;
      bus.op = NOP;
      bus.clr_err = 1'b0;
   endtask

   task automatic do_reset();
      bus.op = NOP;
      bus.clr_err = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic test_reset();
      bus.op = NOP;
      bus.din = '0;
      bus.clr_err = 1'b0;
      reset = 1'b0;
      #12;
      checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus.count); end
      checks++; if (bus.index !== 4'd0) begin failures++; $display("FAIL reset_index got=%0d want=0", bus.index); end
      checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL reset_empty_full got=%b%b want=10", bus.empty, bus.full); end
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b want=00", bus.overflow, bus.underflow); end
      checks++; if (bus.tos !== 8'd0 || bus.nos !== 8'd0) begin failures++; $display("FAIL reset_tos_nos got=%0h/%0h want=0/0", bus.tos, bus.nos); end
      @(negedge clk);
      reset = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic test_push_binop();
      do_reset();
      do_op(PUSH, 8'd4, 1'b0);
      do_op(PUSH, 8'd5, 1'b0);
      checks++; if (bus.tos !== 8'd5 || bus.nos !== 8'd4) begin failures++; $display("FAIL push_tos_nos got=%0d/%0d want=5/4", bus.tos, bus.nos); end
      checks++; if (bus.count !== 5'd2 || bus.index !== 4'd1 || bus.empty !== 1'b0) begin failures++; $display("FAIL push_cnt_idx got=%0d/%0d/%b want=2/1/0", bus.count, bus.index, bus.empty); end
      do_op(BINOP, 8'd9, 1'b0);
      checks++; if (bus.tos !== 8'd9 || bus.nos !== 8'd0) begin failures++; $display("FAIL binop_tos_nos got=%0d/%0d want=9/0", bus.tos, bus.nos); end
      checks++; if (bus.count !== 5'd1 || bus.index !== 4'd0) begin failures++; $display("FAIL binop_cnt_idx got=%0d/%0d want=1/0", bus.count, bus.index); end
      do_op(POP, 8'd0, 1'b0);
      checks++; if (bus.empty !== 1'b1 || bus.tos !== 8'd0) begin failures++; $display("FAIL pop_empty got=%b/%0d want=1/0", bus.empty, bus.tos); end
   endtask

   task automatic test_full_overflow();
      do_reset();
      for (int i = 1; i <= D; i++) do_op(PUSH, W'(i), 1'b0);
      checks++; if (bus.full !== 1'b1 || bus.index !== 4'd15 || bus.tos !== 8'd16) begin failures++; $display("FAIL full_state got=%b/%0d/%0d want=1/15/16", bus.full, bus.index, bus.tos); end
      checks++; if (bus.count !== 5'd16 || bus.nos !== 8'd15) begin failures++; $display("FAIL full_cnt_nos got=%0d/%0d want=16/15", bus.count, bus.nos); end
      do_op(PUSH, 8'hAA, 1'b0);
      checks++; if (bus.overflow !== 1'b1 || bus.tos !== 8'd16 || bus.count !== 5'd16) begin failures++; $display("FAIL overflow got=%b/%0d/%0d want=1/16/16", bus.overflow, bus.tos, bus.count); end
      do_op(NOP, 8'd0, 1'b1);
      checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%b want=0", bus.overflow); end
      // Set wins over clear in the same cycle.
      do_op(PUSH, 8'h55, 1'b1);
      checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL set_wins got=%b want=1", bus.overflow); end
   endtask

   task automatic test_underflow();
      do_reset();
      do_op(POP, 8'd0, 1'b0);
      checks++; if (bus.underflow !== 1'b1 || bus.count !== 5'd0) begin failures++; $display("FAIL pop_underflow got=%b/%0d want=1/0", bus.underflow, bus.count); end
      do_op(PUSH, 8'd3, 1'b0);
      do_op(BINOP, 8'hEE, 1'b0);
      checks++; if (bus.underflow !== 1'b1 || bus.tos !== 8'd3 || bus.count !== 5'd1) begin failures++; $display("FAIL binop_underflow got=%b/%0d/%0d want=1/3/1", bus.underflow, bus.tos, bus.count); end
      do_op(PUSH, 8'hEE, 1'b0);
      checks++; if (int'($signed(bus.tos)) !== -18) begin failures++; $display("FAIL signed_tos got=%0d want=-18", $signed(bus.tos)); end
   endtask

   task automatic test_dup_swap();
      do_reset();
      do_op(PUSH, 8'd2, 1'b0);
      do_op(PUSH, 8'hFC, 1'b0);
      do_op(SWAP, 8'd0, 1'b0);
`ifdef OPERAND_STACK_DUP_SWAP_EN
      checks++; if (bus.tos !== 8'd2 || int'($signed(bus.nos)) !== -4) begin failures++; $display("FAIL swap got=%0d/%0d want=2/-4", bus.tos, $signed(bus.nos)); end
      do_op(DUP, 8'd0, 1'b0);
      checks++; if (bus.count !== 5'd3 || bus.tos !== 8'd2 || bus.nos !== 8'd2) begin failures++; $display("FAIL dup got=%0d/%0d/%0d want=3/2/2", bus.count, bus.tos, bus.nos); end
`else
      checks++; if (int'($signed(bus.tos)) !== -4 || bus.count !== 5'd2) begin failures++; $display("FAIL swap_off got=%0d/%0d want=-4/2", $signed(bus.tos), bus.count); end
      do_op(DUP, 8'd0, 1'b0);
      checks++; if (bus.count !== 5'd2 || bus.tos !== 8'hFC) begin failures++; $display("FAIL dup_off got=%0d/%0h want=2/fc", bus.count, bus.tos); end
`endif
      checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin failures++; $display("FAIL dupswap_flags got=%b%b want=00", bus.overflow, bus.underflow); end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 5; i++) do_op(PUSH, W'(8'h30 + i), 1'b0);
      bus.op = PUSH;
      bus.din = 8'd7;
      #2;
      reset = 1'b0;
      #1;
      checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1 || bus.tos !== 8'd0) begin failures++; $display("FAIL async_reset got=%0d/%b/%0d want=0/1/0", bus.count, bus.empty, bus.tos); end
      @(posedge clk);
      #1;
      checks++; if (bus.count !== 5'd0) begin failures++; $display("FAIL reset_held got=%0d want=0", bus.count); end
      @(negedge clk);
      bus.op = NOP;
      reset = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      do_op(PUSH, 8'd1, 1'b0);
      checks++; if (bus.tos !== 8'd1 || bus.index !== 4'd0 || bus.count !== 5'd1) begin failures++; $display("FAIL post_reset got=%0d/%0d/%0d want=1/0/1", bus.tos, bus.index, bus.count); end
   endtask

   task automatic test_random();
      logic [2:0] op;
      int         r;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 11));
         // Bias toward pushes early in each phase so the full boundary is exercised.
         if (r < 4) op = (n % 200 < 100) ? PUSH : POP;
         else op = 3'($urandom_range(0, 7));
         do_op(op, 8'($urandom), ($urandom_range(0, 9) == 0));
         checks++; if (bus.count !== 5'(mq.size())) begin failures++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.count, mq.size()); end
         checks++; if (bus.tos !== m_tos()) begin failures++; $display("FAIL rnd_tos n=%0d got=%0h want=%0h", n, bus.tos, m_tos()); end
         checks++; if (bus.nos !== m_nos()) begin failures++; $display("FAIL rnd_nos n=%0d got=%0h want=%0h", n, bus.nos, m_nos()); end
         checks++; if (bus.index !== 4'((mq.size() > 0) ? mq.size() - 1 : 0)) begin failures++; $display("FAIL rnd_index n=%0d got=%0d size=%0d", n, bus.index, mq.size()); end
         checks++; if (bus.empty !== (mq.size() == 0) || bus.full !== (mq.size() == D)) begin failures++; $display("FAIL rnd_empty_full n=%0d got=%b%b size=%0d", n, bus.empty, bus.full, mq.size()); end
         checks++; if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin failures++; $display("FAIL rnd_flags n=%0d got=%b%b want=%b%b", n, bus.overflow, bus.underflow, m_ovf, m_unf); end
      end
   endtask

   initial begin
      test_reset();
      test_push_binop();
      test_full_overflow();
      test_underflow();
      test_dup_swap();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
